// File: rtl/gf2_poly_div_161.sv
// gf2_poly_div_161
// Bit-serial GF(2) polynomial divider. Divides a 161-bit dividend by an 81-bit
// divisor using carry-less (XOR) long division and produces one quotient bit
// per clock. It is the inverse path of the 81x81 carry-less multiplier, so it
// can take that multiplier's 161-bit product directly.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   in_valid_i     dividend/divisor presented
//   in_ready_o     block can accept an operand pair (IDLE only)
//   dividend_i     dividend polynomial, bit i = coefficient of x^i
//   divisor_i      divisor polynomial, bit i = coefficient of x^i
//   out_valid_o    result valid, held until out_ready_i
//   out_ready_i    consumer accepts the result
//   quotient_o     quotient polynomial
//   remainder_o    remainder polynomial, degree < deg(divisor)
//   div_by_zero_o  divisor was all-zero; quotient/remainder forced to 0
//
// State table
//   ST_IDLE | waiting for an operand pair, in_ready_o high
//   ST_DIV  | one long-division step per cycle, cnt_q steps remaining
//   ST_DONE | result registered on the outputs, waiting for out_ready_i

module gf2_poly_div_161 (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [160:0]  dividend_i,
  input  logic [80:0]   divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [160:0]  quotient_o,
  output logic [79:0]   remainder_o,
  output logic          div_by_zero_o
);

  localparam int N  = 161;
  localparam int M  = 81;
  localparam int CW = 8;
  localparam int DW = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [N-1:0]    s_q;          // dividend shifting out, quotient shifting in
  logic [M-1:0]    den_q;        // latched divisor
  logic [M-2:0]    r_q;          // partial remainder, degree < deg_q
  logic [DW-1:0]   deg_q;        // degree of the latched divisor
  logic [CW-1:0]   cnt_q;        // division steps still to run
  logic [N-1:0]    quotient_q;
  logic [M-2:0]    remainder_q;
  logic            out_valid_q;
  logic            dbz_q;

  logic [M-1:0]    t_d;
  logic [M-1:0]    x_d;
  logic            qbit_d;
  logic [M-2:0]    r_d;
  logic [N-1:0]    s_d;
  logic            unused_x_msb;

  // Highest set bit of the divisor; 0 when the divisor is 0 or 1.
  function automatic logic [DW-1:0] msb_index(input logic [M-1:0] v);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i < M; i++) begin
      if (v[i]) idx = DW'(i);
    end
    return idx;
  endfunction

  // One long-division step: bring down the next dividend bit, and if the
  // working value reaches the divisor's degree, subtract (XOR) the divisor.
  // The working value never exceeds degree deg_q, so after the XOR bit M-1
  // is always clear and the partial remainder fits in M-1 bits.
  always_comb begin
    t_d    = {r_q, s_q[N-1]};
    qbit_d = t_d[deg_q];
    x_d    = t_d ^ den_q;
    r_d    = qbit_d ? x_d[M-2:0] : t_d[M-2:0];
    s_d    = {s_q[N-2:0], qbit_d};
  end

  assign unused_x_msb = x_d[M-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      den_q       <= '0;
      r_q         <= '0;
      deg_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            den_q       <= divisor_i;
            deg_q       <= msb_index(divisor_i);
            dbz_q       <= (divisor_i == '0);
            state_q     <= ST_DIV;
            if (divisor_i == '0) begin
              // A single step on an all-zero working set yields zero
              // quotient and remainder and gives the one-cycle latency.
              s_q   <= '0;
              cnt_q <= CW'(1);
            end else begin
              s_q   <= dividend_i;
              cnt_q <= CW'(N);
            end
          end
        end

        ST_DIV: begin
          s_q   <= s_d;
          r_q   <= r_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_q  <= s_d;
            remainder_q <= r_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o    = (state_q == ST_IDLE);
  assign out_valid_o   = out_valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_gf2_poly_div_161.sv
module tb_gf2_poly_div_161;

  localparam int N = 161;
  localparam int M = 81;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  dividend;
  logic [M-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  quotient;
  logic [M-2:0]  remainder;
  logic          dbz;

  int n_vec = 0;
  int n_err = 0;

  gf2_poly_div_161 dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-2:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t tbl[6];

  function automatic void chk_vec(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [M-1:0] rand81();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  function automatic logic [N-1:0] rand161();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  function automatic int degree(logic [M-1:0] b);
    int d;
    d = -1;
    for (int i = 0; i < M; i++) if (b[i]) d = i;
    return d;
  endfunction

  // Carry-less product, as the 81x81 multiplier would produce it.
  function automatic logic [N-1:0] clmul(logic [M-1:0] a, logic [M-1:0] b);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{(N-M){1'b0}}, a} << i);
    return p;
  endfunction

  // Textbook long division: cancel the leading term of the running
  // remainder with a shifted copy of the divisor, top degree downwards.
  function automatic void ref_div(input logic [N-1:0] a, input logic [M-1:0] b,
                                  output logic [N-1:0] q, output logic [M-2:0] r,
                                  output logic z);
    logic [N-1:0] rem;
    int db;
    q = '0;
    r = '0;
    z = (b == '0);
    if (!z) begin
      db  = degree(b);
      rem = a;
      for (int i = N - 1; i >= db; i--) begin
        if (rem[i]) begin
          rem = rem ^ ({{(N-M){1'b0}}, b} << (i - db));
          q[i - db] = 1'b1;
        end
      end
      r = rem[M-2:0];
    end
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk_int("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 400);
    if (!out_valid) chk_int("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_div(input logic [N-1:0] a, input logic [M-1:0] b,
                         output logic [N-1:0] q, output logic [M-2:0] r,
                         output logic z, output int lat);
    wait_ready();
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = rand161();
    divisor  = rand81();
    wait_valid(lat);
    q = quotient;
    r = remainder;
    z = dbz;
    release_result();
  endtask

  initial begin
    logic [N-1:0] q, eq, a2q;
    logic [M-2:0] r, er, a2r;
    logic         z, ez, a2z;
    logic [M-1:0] ra, rb, b2;
    logic [N-1:0] c, a2;
    logic [M-2:0] rr;
    logic [N-1:0] rnd;
    int lat, db;

    rnd = rand161();
    tbl[0] = '{a: N'(5), b: M'(3), q: N'(3), r: '0, z: 1'b0, lat: N};
    tbl[1] = '{a: N'(7), b: M'(3), q: N'(2), r: (M-1)'(1), z: 1'b0, lat: N};
    tbl[2] = '{a: N'(1) << 160, b: M'(1) << 80, q: N'(1) << 80, r: '0, z: 1'b0, lat: N};
    tbl[3] = '{a: '1, b: '0, q: '0, r: '0, z: 1'b1, lat: 1};
    tbl[4] = '{a: rnd, b: M'(1), q: rnd, r: '0, z: 1'b0, lat: N};
    tbl[5] = '{a: N'(1) << 160, b: (M'(1) << 80) | M'(1), q: (N'(1) << 80) | N'(1),
               r: (M-1)'(1), z: 1'b0, lat: N};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_vec("rst_quotient", quotient, '0);
    chk_vec("rst_remainder", N'(remainder), '0);
    chk_int("rst_dbz", int'(dbz), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_int("post_rst_in_ready", int'(in_ready), 1);

    // Reset and in_valid together: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; dividend = N'(5); divisor = M'(3);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_int("rst_wins_in_ready", int'(in_ready), 1);
    chk_int("rst_wins_out_valid", int'(out_valid), 0);

    for (int i = 0; i < 6; i++) begin
      run_div(tbl[i].a, tbl[i].b, q, r, z, lat);
      chk_vec($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk_vec($sformatf("tbl%0d_r", i), N'(r), N'(tbl[i].r));
      chk_int($sformatf("tbl%0d_dbz", i), int'(z), int'(tbl[i].z));
      chk_int($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end

    // Round trips through the carry-less product, alternately with an
    // added remainder of lower degree than the divisor.
    for (int i = 0; i < 160; i++) begin
      ra = rand81();
      rb = rand81();
      if (i % 4 == 3) rb = rb >> $urandom_range(80, 0);
      if (rb == '0) rb = M'(1);
      c  = clmul(ra, rb);
      rr = '0;
      if (i % 2 == 1) begin
        db = degree(rb);
        for (int k = 0; k < db; k++) rr[k] = 1'($urandom_range(1, 0));
        c = c ^ N'(rr);
      end
      run_div(c, rb, q, r, z, lat);
      chk_vec($sformatf("rt%0d_q", i), q, N'(ra));
      chk_vec($sformatf("rt%0d_r", i), N'(r), N'(rr));
      if (z !== 1'b0 || lat != N) chk_int($sformatf("rt%0d_lat_dbz", i), lat + int'(z), N);
    end

    // Unstructured dividends against the reference model.
    for (int i = 0; i < 30; i++) begin
      a2 = rand161();
      b2 = rand81() >> $urandom_range(80, 0);
      ref_div(a2, b2, eq, er, ez);
      run_div(a2, b2, q, r, z, lat);
      chk_vec($sformatf("rnd%0d_q", i), q, eq);
      chk_vec($sformatf("rnd%0d_r", i), N'(r), N'(er));
      chk_int($sformatf("rnd%0d_dbz", i), int'(z), int'(ez));
      chk_int($sformatf("rnd%0d_lat", i), lat, ez ? 1 : N);
    end

    // Backpressure: result held 20 cycles, a queued request waits.
    a2 = rand161();
    b2 = rand81() | M'(1);
    ref_div(a2, b2, eq, er, ez);
    wait_ready();
    dividend = a2; divisor = b2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk_int("bp_lat", lat, N);
    a2 = rand161();
    b2 = rand81() | (M'(1) << 40);
    ref_div(a2, b2, a2q, a2r, a2z);
    dividend = a2; divisor = b2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk_int($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
      chk_int($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
      chk_vec($sformatf("bp%0d_q", i), quotient, eq);
      chk_vec($sformatf("bp%0d_r", i), N'(remainder), N'(er));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_int("bp_release_in_ready", int'(in_ready), 1);
    chk_int("bp_release_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_int("bp_queued_accepted", int'(in_ready), 0);
    wait_valid(lat);
    chk_int("bp_queued_lat", lat, N);
    chk_vec("bp_queued_q", quotient, a2q);
    chk_vec("bp_queued_r", N'(remainder), N'(a2r));
    release_result();

    // Reset in the middle of a division.
    wait_ready();
    dividend = rand161(); divisor = rand81() | M'(2); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_vec("mid_rst_q", quotient, '0);
    chk_int("mid_rst_in_ready", int'(in_ready), 1);
    a2 = rand161();
    b2 = rand81() | (M'(1) << 7);
    ref_div(a2, b2, eq, er, ez);
    run_div(a2, b2, q, r, z, lat);
    chk_vec("after_rst_q", q, eq);
    chk_vec("after_rst_r", N'(r), N'(er));
    chk_int("after_rst_lat", lat, N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
